// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA generator: 640x480 @ 60 Hz defaults
// and the default coordinate and frame-counter widths.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam bit SYNC_POL_DEF = 1'b0;
  localparam int CW_DEF       = 16;
  localparam int FCW_DEF      = 8;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One timing axis (horizontal or vertical): a wrapping counter with registered
// sync/active decodes that always describe the count presented in the same cycle.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          active,
  output logic          terminal
);

  localparam int            TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          sync_reg;
  logic          active_reg;

  assign terminal = (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (restart) begin
      count_next = '0;
    end else if (advance) begin
      count_next = terminal ? '0 : count_reg + CW'(1);
    end
  end

  // Decodes are taken from the next count so they land together with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      sync_reg   <= 1'b0;
      active_reg <= 1'b1;
    end else begin
      count_reg  <= count_next;
      sync_reg   <= (count_next >= SYNC_START) && (count_next <= SYNC_END);
      active_reg <= (count_next < ACT_END);
    end
  end

  assign count  = count_reg;
  assign sync   = sync_reg;
  assign active = active_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y coordinates, sync and data-enable decodes,
// line/frame strobes and a completed-frame counter, advanced by a pixel enable.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF,
  parameter int CW       = CW_DEF,
  parameter int FCW      = FCW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pix_en,
  input  logic           restart,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_end,
  output logic           frame,
  output logic [FCW-1:0] frame_count
);

  localparam logic [CW-1:0] X_LAST_ACT = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST_ACT = CW'(V_ACTIVE - 1);

  logic           h_sync, h_active, h_term;
  logic           v_sync, v_active, v_term;
  logic           v_adv;
  logic           wrap;
  logic [FCW-1:0] frame_count_reg;

  assign v_adv = pix_en & h_term;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (pix_en),
    .restart  (restart),
    .count    (x),
    .sync     (h_sync),
    .active   (h_active),
    .terminal (h_term)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (v_adv),
    .restart  (restart),
    .count    (y),
    .sync     (v_sync),
    .active   (v_active),
    .terminal (v_term)
  );

  assign hsync = SYNC_POL ? h_sync : ~h_sync;
  assign vsync = SYNC_POL ? v_sync : ~v_sync;
  assign de    = h_active & v_active;

  // A restart in the same cycle wins over the strobes and the frame increment.
  assign line_end = pix_en & h_term & ~restart;
  assign frame    = pix_en & ~restart & (x == X_LAST_ACT) & (y == Y_LAST_ACT);
  assign wrap     = pix_en & h_term & v_term & ~restart;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= '0;
    end else if (wrap) begin
      frame_count_reg <= frame_count_reg + FCW'(1);
    end
  end

  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 800x525 instance and a small 14x7 instance are
// driven by directed sequences; a per-instance monitor checks every cycle.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        le;
    logic        fr;
    logic [7:0]  fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        d_rst_n = 1'b0, d_pe = 1'b0, d_rs = 1'b0;
  logic [15:0] d_x, d_y;
  logic        d_hs, d_vs, d_de, d_le, d_fr;
  logic [7:0]  d_fc;

  // small instance: H 8/2/2/2, V 4/1/1/1, active-high sync, 2-bit frame counter
  logic        s_rst_n = 1'b0, s_pe = 1'b0, s_rs = 1'b0;
  logic [15:0] s_x, s_y;
  logic        s_hs, s_vs, s_de, s_le, s_fr;
  logic [1:0]  s_fc;

  vga_timing_gen u_dflt (
    .clk(clk), .reset_n(d_rst_n), .pix_en(d_pe), .restart(d_rs),
    .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .line_end(d_le), .frame(d_fr), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CW(16), .FCW(2)
  ) u_small (
    .clk(clk), .reset_n(s_rst_n), .pix_en(s_pe), .restart(s_rs),
    .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .line_end(s_le), .frame(s_fr), .frame_count(s_fc)
  );

  exp_t q_d[$];
  exp_t q_s[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   d_done = 1'b0;
  bit   s_done = 1'b0;

  // ---------------- expected-value models (hand-derived constants) ----------
  function automatic exp_t d_exp(input int x, input int y, input int fc, input bit pe, input bit rs);
    exp_t e;
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.hs = !(x >= 656 && x <= 751);
    e.vs = !(y >= 490 && y <= 491);
    e.de = (x < 640) && (y < 480);
    e.le = pe && !rs && (x == 799);
    e.fr = pe && !rs && (x == 639) && (y == 479);
    e.fc = 8'(fc % 256);
    return e;
  endfunction

  function automatic exp_t s_exp(input int x, input int y, input int fc, input bit pe, input bit rs);
    exp_t e;
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.hs = (x >= 10 && x <= 11);
    e.vs = (y == 5);
    e.de = (x < 8) && (y < 4);
    e.le = pe && !rs && (x == 13);
    e.fr = pe && !rs && (x == 7) && (y == 3);
    e.fc = 8'(fc % 4);
    return e;
  endfunction

  // ---------------- default instance stimulus ------------------------------
  int d_mx = 0, d_my = 0, d_mfc = 0;

  task automatic d_cycle(input bit pe, input bit rs);
    d_pe = pe;
    d_rs = rs;
    q_d.push_back(d_exp(d_mx, d_my, d_mfc, pe, rs));
    if (rs) begin
      d_mx = 0;
      d_my = 0;
    end else if (pe) begin
      if (d_mx == 799) begin
        d_mx = 0;
        if (d_my == 524) begin
          d_my = 0;
          d_mfc++;
        end else begin
          d_my++;
        end
      end else begin
        d_mx++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic d_reset_now();
    d_pe = 1'b0;
    d_rs = 1'b0;
    d_rst_n = 1'b0;
    d_mx = 0; d_my = 0; d_mfc = 0;
    q_d.push_back(d_exp(0, 0, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    q_d.push_back(d_exp(0, 0, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    d_rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    d_reset_now();
    $display("[tb] dflt: reset released");
    repeat (2300) d_cycle(1'b1, 1'b0);
    $display("[tb] dflt: ran to (700,2), applying restart");
    d_cycle(1'b1, 1'b1);
    repeat (400) d_cycle(1'b1, 1'b0);
    $display("[tb] dflt: async reset at (400,0)");
    d_reset_now();
    for (int i = 0; i < 3400; i++) d_cycle((i % 4) == 0, 1'b0);
    $display("[tb] dflt: 1-in-4 enable run done");
    repeat (749) d_cycle(1'b1, 1'b0);
    $display("[tb] dflt: restart at line end (799,1)");
    d_cycle(1'b1, 1'b1);
    repeat (20) d_cycle(1'b1, 1'b0);
    d_done = 1'b1;
  end

  // ---------------- small instance stimulus --------------------------------
  int s_mx = 0, s_my = 0, s_mfc = 0;

  task automatic s_cycle(input bit pe, input bit rs);
    s_pe = pe;
    s_rs = rs;
    q_s.push_back(s_exp(s_mx, s_my, s_mfc, pe, rs));
    if (rs) begin
      s_mx = 0;
      s_my = 0;
    end else if (pe) begin
      if (s_mx == 13) begin
        s_mx = 0;
        if (s_my == 6) begin
          s_my = 0;
          s_mfc++;
        end else begin
          s_my++;
        end
      end else begin
        s_mx++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic s_reset_now();
    s_pe = 1'b0;
    s_rs = 1'b0;
    s_rst_n = 1'b0;
    s_mx = 0; s_my = 0; s_mfc = 0;
    q_s.push_back(s_exp(0, 0, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    q_s.push_back(s_exp(0, 0, 0, 1'b0, 1'b0));
    @(posedge clk); #1;
    s_rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    s_reset_now();
    $display("[tb] small: reset released");
    repeat (490) s_cycle(1'b1, 1'b0);
    $display("[tb] small: five frames done, counter passed 3->0");
    repeat (38) s_cycle(1'b1, 1'b0);
    s_cycle(1'b1, 1'b1);
    $display("[tb] small: restart at (10,2) done");
    repeat (97) s_cycle(1'b1, 1'b0);
    s_cycle(1'b1, 1'b1);
    $display("[tb] small: restart at (13,6) done");
    repeat (20) s_cycle(1'b1, 1'b0);
    repeat (5) s_cycle(1'b0, 1'b0);
    s_cycle(1'b0, 1'b1);
    $display("[tb] small: hold and restart without enable done");
    for (int i = 0; i < 784; i++) s_cycle((i % 4) == 3, 1'b0);
    $display("[tb] small: 1-in-4 enable run done");
    repeat (19) s_cycle(1'b1, 1'b0);
    s_reset_now();
    $display("[tb] small: async reset at (5,1) done");
    repeat (30) s_cycle(1'b1, 1'b0);
    s_done = 1'b1;
  end

  // ---------------- monitors ----------------------------------------------
  task automatic compare(input string nm, input exp_t a, input exp_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @%0t: got x=%0d y=%0d hs=%b vs=%b de=%b le=%b fr=%b fc=%0d, required x=%0d y=%0d hs=%b vs=%b de=%b le=%b fr=%b fc=%0d",
                 nm, $time, a.x, a.y, a.hs, a.vs, a.de, a.le, a.fr, a.fc,
                 e.x, e.y, e.hs, e.vs, e.de, e.le, e.fr, e.fc);
    end
  endtask

  always @(negedge clk) begin
    automatic exp_t e;
    automatic exp_t a;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      a = '{x: d_x, y: d_y, hs: d_hs, vs: d_vs, de: d_de, le: d_le, fr: d_fr, fc: d_fc};
      compare("dflt", a, e);
    end
  end

  always @(negedge clk) begin
    automatic exp_t e;
    automatic exp_t a;
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      a = '{x: s_x, y: s_y, hs: s_hs, vs: s_vs, de: s_de, le: s_le, fr: s_fr, fc: {6'b0, s_fc}};
      compare("small", a, e);
    end
  end

  // ---------------- end of test --------------------------------------------
  initial begin
    fork
      wait (d_done && s_done);
      #1ms;
    join_any
    disable fork;
    repeat (3) @(negedge clk);
    n_chk++;
    if (!(d_done && s_done) || q_d.size() != 0 || q_s.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got done=%b/%b pending=%0d/%0d, required done=1/1 pending=0/0",
               d_done, s_done, q_d.size(), q_s.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
